sig_debounce: RTL and testbench
===============================

// Module: sig_debounce
// PURPOSE
//  Input conditioner for asynchronous control/status levels (buttons, external enables, codec status pins).
//  Synchronises sig_async into clk, rejects glitches shorter than STABLE_CYCLES, emits a clean level plus
//  registered rise/fall strobes. sig_clean feeds the common positive-edge detector stage directly downstream.
// PARAMETERS
//  SYNC_STAGES    2     synchroniser depth; legal range >= 2 (elaboration error otherwise)
//  STABLE_CYCLES  1000  consecutive differing sampled cycles required to accept a new level; >= 1
//  RESET_LEVEL    1'b0  value of sync chain and sig_clean in reset
//  CNT_W          localparam = $clog2(STABLE_CYCLES+1); not overridable
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  sig_async  in   1      raw asynchronous input level
//  en         in   1      qualification enable; 0 freezes sig_clean
//  sig_clean  out  1      debounced level, registered
//  rise       out  1      one-cycle strobe, coincident with sig_clean 0->1
//  fall       out  1      one-cycle strobe, coincident with sig_clean 1->0
//  busy       out  1      1 while in QUAL (candidate level being timed)
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert by system): sync chain=RESET_LEVEL, sig_clean=RESET_LEVEL,
//    rise=fall=busy=0, cnt=0, state=STABLE. Takes effect immediately, including mid-QUAL; no strobe emitted.
//  - sync_out = last stage of SYNC_STAGES-deep flop chain; chain runs every cycle regardless of en.
//  - FSM {STABLE, QUAL}; diff = (sync_out != sig_clean).
//    STABLE: diff&en & STABLE_CYCLES==1 -> toggle sig_clean, strobe, stay STABLE.
//            diff&en otherwise -> QUAL, cnt=1. Else stay, cnt=0.
//    QUAL:   !en -> STABLE, cnt=0 (candidate discarded).
//            !diff -> STABLE, cnt=0 (glitch rejected, no strobe).
//            diff & cnt==STABLE_CYCLES-1 -> toggle sig_clean, strobe, STABLE, cnt=0.
//            diff otherwise -> cnt++.
//  - sig_clean changes at the edge closing the STABLE_CYCLES-th consecutive en=1 cycle with diff=1.
//    Latency, sig_async step (first sampling edge) -> sig_clean: SYNC_STAGES+STABLE_CYCLES edges.
//  - rise/fall registered, high exactly the cycle sig_clean holds its new value; never both high.
//  - cnt never exceeds STABLE_CYCLES-1; no wrap possible by construction.
//  - en=0: sig_clean, rise=fall=0 held; re-enable restarts qualification from cnt=0.
//  - Input toggling faster than STABLE_CYCLES: sig_clean never changes.
//  - busy = (state==QUAL), registered.
// STRUCTURE
//  - llac_common_pkg: typedef enum logic {DB_STABLE, DB_QUAL} debounce_state_t; SYNC_MIN_STAGES=2 constant.
//  - Sub-module sync_ff_chain #(STAGES, RESET_LEVEL): plain flop chain, async reset; reused elsewhere.
//  - Top: FSM + counter + output registers; one always_ff for state, one always_comb for next-state.
// TESTING (SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=0 unless noted)
//  1 Step 0->1 held, en=1 -> sig_clean=1 at 6th edge after first sampling edge; rise=1 that cycle only.
//  2 Pulse of 3 cycles, 1 cycle fewer than required -> sig_clean stays 0, rise never asserts, busy 1 for 3 cycles.
//  3 Step 1->0 after settled high -> fall pulse, sig_clean=0 after 6 edges; rise stays 0.
//  4 rst asserted mid-QUAL (cnt=2) -> all outputs 0 same cycle asynchronously; after release input must requalify fully.
//  5 en=0 during held step -> sig_clean frozen; en=1 -> sig_clean changes 4 edges after re-enable.
//  6 STABLE_CYCLES=1, RESET_LEVEL=1 -> reset sig_clean=1; 0 step -> fall at 3rd edge; busy never asserts.

Source files
------------

// File: rtl/llac_common_pkg.sv
// Shared types and constants for the level-conditioning blocks.
//   debounce_state_t : debouncer FSM encoding (stable level / qualifying a candidate)
//   SYNC_MIN_STAGES  : shallowest synchroniser chain considered metastability-safe
package llac_common_pkg;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_QUAL   = 1'b1
    } debounce_state_t;

    localparam int SYNC_MIN_STAGES = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// Plain flop chain for bringing an asynchronous level into the clk domain.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset; every stage loads RESET_LEVEL
//   d    in  asynchronous input level
//   q    out last stage of the chain (STAGES cycles of delay)
module sync_ff_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_LEVEL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// Debouncer for asynchronous control/status levels. The input is synchronised,
// then a new level is accepted only after STABLE_CYCLES consecutive enabled
// cycles in which the synchronised level differs from the current clean level.
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous, active-high reset
//   sig_async  in  raw asynchronous input level
//   en         in  qualification enable; 0 freezes sig_clean and drops any candidate
//   sig_clean  out debounced level, registered
//   rise       out one-cycle strobe, high the cycle sig_clean becomes 1
//   fall       out one-cycle strobe, high the cycle sig_clean becomes 0
//   busy       out high while a candidate level is being timed
module sig_debounce
    import llac_common_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 1000,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_async,
    input  logic en,
    output logic sig_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Count value at which the STABLE_CYCLES-th differing cycle is being closed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < SYNC_MIN_STAGES) begin : g_bad_sync_stages
            $error("sig_debounce: SYNC_STAGES must be >= %0d", SYNC_MIN_STAGES);
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("sig_debounce: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    logic sync_out;

    sync_ff_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_async),
        .q   (sync_out)
    );

    debounce_state_t  state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             clean_n, rise_n, fall_n;
    logic             diff;

    assign diff = (sync_out != sig_clean);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clean_n = sig_clean;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            DB_STABLE: begin
                cnt_n = '0;
                if (diff && en) begin
                    if (STABLE_CYCLES == 1) begin
                        // One differing cycle is enough: accept without visiting QUAL.
                        clean_n = ~sig_clean;
                        rise_n  = ~sig_clean;
                        fall_n  = sig_clean;
                    end else begin
                        // This cycle already counts as the first differing one.
                        state_n = DB_QUAL;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            DB_QUAL: begin
                if (!en || !diff) begin
                    state_n = DB_STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    clean_n = ~sig_clean;
                    rise_n  = ~sig_clean;
                    fall_n  = sig_clean;
                    state_n = DB_STABLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = DB_STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DB_STABLE;
            cnt       <= '0;
            sig_clean <= RESET_LEVEL;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sig_clean <= clean_n;
            rise      <= rise_n;
            fall      <= fall_n;
        end
    end

    assign busy = (state == DB_QUAL);

endmodule

// File: tb/tb_sig_debounce.sv
module tb_sig_debounce;

    localparam int SYNC = 2;

    logic clk;
    logic rst;
    logic sig_async;
    logic en;
    logic a_clean, a_rise, a_fall, a_busy;
    logic b_clean, b_rise, b_fall, b_busy;

    int total = 0;
    int bad   = 0;
    int b_busy_hits = 0;

    // Instance A: STABLE_CYCLES=4, RESET_LEVEL=0
    sig_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) u_a (
        .clk       (clk),
        .rst       (rst),
        .sig_async (sig_async),
        .en        (en),
        .sig_clean (a_clean),
        .rise      (a_rise),
        .fall      (a_fall),
        .busy      (a_busy)
    );

    // Instance B: STABLE_CYCLES=1, RESET_LEVEL=1
    sig_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) u_b (
        .clk       (clk),
        .rst       (rst),
        .sig_async (sig_async),
        .en        (en),
        .sig_clean (b_clean),
        .rise      (b_rise),
        .fall      (b_fall),
        .busy      (b_busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // hist[d][k] = input level sampled k+1 edges ago; the debouncer acts on
    // the sample taken SYNC edges before the current one.
    bit [63:0]  hist [2];
    logic       m_clean [2];
    int         m_run [2];
    int         n_req [2] = '{4, 1};
    logic       m_rl [2]  = '{1'b0, 1'b1};
    logic [3:0] exp_a [$];
    logic [3:0] exp_b [$];

    task automatic model_step(input int d, output logic [3:0] e);
        logic s, r, f;
        r = 1'b0;
        f = 1'b0;
        if (rst) begin
            hist[d]    = {64{m_rl[d]}};
            m_clean[d] = m_rl[d];
            m_run[d]   = 0;
        end else begin
            s = hist[d][SYNC-1];
            if (en && (s != m_clean[d])) begin
                m_run[d] = m_run[d] + 1;
                if (m_run[d] == n_req[d]) begin
                    m_clean[d] = ~m_clean[d];
                    r = m_clean[d];
                    f = ~m_clean[d];
                    m_run[d] = 0;
                end
            end else begin
                m_run[d] = 0;
            end
            hist[d] = {hist[d][62:0], sig_async};
        end
        e = {m_clean[d], r, f, (m_run[d] != 0)};
    endtask

    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            model_step(0, e);
            exp_a.push_back(e);
            model_step(1, e);
            exp_b.push_back(e);
        end
    end

    // ---------------- comparison ----------------
    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (b_busy) b_busy_hits++;
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("a_outputs{clean,rise,fall,busy}", {a_clean, a_rise, a_fall, a_busy}, e);
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("b_outputs{clean,rise,fall,busy}", {b_clean, b_rise, b_fall, b_busy}, e);
            end
        end
    end

    // ---------------- driver helpers ----------------
    // Counts posedges until the chosen instance's sig_clean reaches target;
    // returns -1 if the bound expires.
    task automatic measure(input int which, input logic target, output int n);
        logic v;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            v = (which == 0) ? a_clean : b_clean;
            if (v == target) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int busy_cnt;
        int rise_cnt;

        rst       = 1'b1;
        en        = 1'b1;
        sig_async = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a_clean", a_clean, 0);
        check("reset_a_strobes_busy", {a_rise, a_fall, a_busy}, 0);
        check("reset_b_clean", b_clean, 1);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // short pulse: 3 sampled cycles high, one fewer than required
        busy_cnt = 0;
        rise_cnt = 0;
        sig_async = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            busy_cnt += int'(a_busy);
            rise_cnt += int'(a_rise);
            if (i == 2) begin
                @(negedge clk);
                sig_async = 1'b0;
            end
        end
        check("pulse_busy_cycles", busy_cnt, 3);
        check("pulse_rise_count", rise_cnt, 0);
        check("pulse_clean", a_clean, 0);

        // held step 0->1
        @(negedge clk);
        sig_async = 1'b1;
        measure(0, 1'b1, n);
        check("rise_latency", n, 6);
        check("rise_strobe", a_rise, 1);
        repeat (5) @(negedge clk);

        // held step 1->0
        sig_async = 1'b0;
        measure(0, 1'b0, n);
        check("fall_latency", n, 6);
        check("fall_strobe", {a_fall, a_rise}, 2'b10);
        repeat (5) @(negedge clk);

        // reset in the middle of qualification (cnt=2)
        sig_async = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_qual_busy", a_busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_a", {a_clean, a_rise, a_fall, a_busy}, 0);
        check("async_reset_b_clean", b_clean, 1);
        @(negedge clk);
        rst = 1'b0;
        measure(0, 1'b1, n);
        check("requalify_latency", n, 6);
        repeat (5) @(negedge clk);

        // enable low freezes the level; re-enable restarts from zero
        en = 1'b0;
        sig_async = 1'b0;
        repeat (12) @(negedge clk);
        check("frozen_clean", a_clean, 1);
        check("frozen_busy", a_busy, 0);
        en = 1'b1;
        measure(0, 1'b0, n);
        check("reenable_latency", n, 4);
        repeat (5) @(negedge clk);

        // STABLE_CYCLES=1, RESET_LEVEL=1 instance
        sig_async = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("b_reset_level", b_clean, 1);
        repeat (4) @(negedge clk);
        sig_async = 1'b0;
        measure(1, 1'b0, n);
        check("b_fall_latency", n, 3);
        check("b_fall_strobe", b_fall, 1);
        repeat (3) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) sig_async = ~sig_async;
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (8) @(negedge clk);

        check("b_busy_never", b_busy_hits, 0);
        check("queue_a_drained", exp_a.size(), 0);
        check("queue_b_drained", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
